// File: rtl/qick_bit2vec_pkg.sv
// Shared definitions for the bit-to-vector collector.
// Contents: FSM state encoding, input-count ceiling, mode constants and a
// helper that builds the mask of active input lanes.
package qick_bit2vec_pkg;

  localparam int MAX_IN = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic MODE_LEVEL  = 1'b0;
  localparam logic MODE_STICKY = 1'b1;

  // Lanes [n-1:0] set, everything above cleared.
  function automatic logic [MAX_IN-1:0] in_mask(input int n);
    logic [MAX_IN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_IN; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/qick_sync_bit.sv
// Multi-stage single-bit synchronizer into the clk_i domain.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset, clears every stage
//   d_i    - asynchronous input bit
//   q_o    - synchronized bit, STAGES cycles after capture
module qick_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/qick_bit2vec.sv
// Collects up to 16 asynchronous single-bit inputs into one packed vector.
// LEVEL mode mirrors the synchronized levels and pulses dout_chg_o on change;
// STICKY mode captures rising edges and hands snapshots over with valid/ready.
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   din0..din15     - asynchronous inputs, dinN -> dout_o[N]
//   sticky_i        - mode select (0 LEVEL, 1 STICKY), quasi-static
//   dout_rdy_i      - consumer ready (STICKY only)
//   dout_o          - packed output vector
//   dout_vld_o      - STICKY snapshot valid
//   dout_chg_o      - LEVEL change pulse
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no snapshot offered; LEVEL mode always sits here
// ST_HOLD | snapshot on dout_o with dout_vld_o=1, waiting for dout_rdy_i
module qick_bit2vec
  import qick_bit2vec_pkg::*;
#(
  parameter int OUT_DW  = 16,
  parameter int IN_QTY  = 16,
  parameter int SYNC_ST = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              din0,
  input  logic              din1,
  input  logic              din2,
  input  logic              din3,
  input  logic              din4,
  input  logic              din5,
  input  logic              din6,
  input  logic              din7,
  input  logic              din8,
  input  logic              din9,
  input  logic              din10,
  input  logic              din11,
  input  logic              din12,
  input  logic              din13,
  input  logic              din14,
  input  logic              din15,
  input  logic              sticky_i,
  input  logic              dout_rdy_i,
  output logic [OUT_DW-1:0] dout_o,
  output logic              dout_vld_o,
  output logic              dout_chg_o
);

  // Lanes beyond IN_QTY, or beyond what dout_o can carry, are tied off
  // before the synchronizers so their flops collapse to constants.
  localparam int N_ACT = (IN_QTY < OUT_DW) ? IN_QTY : OUT_DW;
  localparam logic [MAX_IN-1:0] ACT_MASK = in_mask(N_ACT);

  if (OUT_DW < IN_QTY) begin : g_trunc_warn
    $warning("qick_bit2vec: OUT_DW < IN_QTY, upper inputs are truncated");
  end

  logic [MAX_IN-1:0] din_vec;
  logic [MAX_IN-1:0] q;
  logic [MAX_IN-1:0] edge_v;
  logic [MAX_IN-1:0] pend_edge;

  assign din_vec = {din15, din14, din13, din12, din11, din10, din9, din8,
                    din7, din6, din5, din4, din3, din2, din1, din0} & ACT_MASK;

  for (genvar i = 0; i < MAX_IN; i++) begin : g_sync
    qick_sync_bit #(.STAGES(SYNC_ST)) u_sync (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .d_i   (din_vec[i]),
      .q_o   (q[i])
    );
  end

  state_e            state_q, state_d;
  logic              m_q, m_d;
  logic [MAX_IN-1:0] q_prev_q, q_prev_d;
  logic [MAX_IN-1:0] pend_q, pend_d;
  logic [MAX_IN-1:0] dout_q, dout_d;
  logic              chg_q, chg_d;

  assign edge_v    = q & ~q_prev_q;
  assign pend_edge = pend_q | edge_v;

  always_comb begin
    state_d  = state_q;
    m_d      = sticky_i;
    q_prev_d = q;
    pend_d   = pend_q;
    dout_d   = dout_q;
    chg_d    = 1'b0;

    if (sticky_i != m_q) begin
      // Mode change: flush everything, edges seen this cycle are dropped.
      state_d = ST_IDLE;
      pend_d  = '0;
      dout_d  = '0;
    end else if (m_q == MODE_LEVEL) begin
      state_d = ST_IDLE;
      dout_d  = q;
      chg_d   = (q != dout_q);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pend_edge != '0) begin
            dout_d  = pend_edge;
            pend_d  = '0;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!dout_rdy_i) begin
            pend_d = pend_edge;
          end else if (pend_edge != '0) begin
            // Handshake and new edges together: reload without a bubble.
            dout_d = pend_edge;
            pend_d = '0;
          end else begin
            dout_d  = '0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      m_q      <= MODE_LEVEL;
      q_prev_q <= '0;
      pend_q   <= '0;
      dout_q   <= '0;
      chg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      q_prev_q <= q_prev_d;
      pend_q   <= pend_d;
      dout_q   <= dout_d;
      chg_q    <= chg_d;
    end
  end

  for (genvar i = 0; i < OUT_DW; i++) begin : g_out
    if (i < MAX_IN) begin : g_live
      assign dout_o[i] = dout_q[i];
    end else begin : g_zero
      assign dout_o[i] = 1'b0;
    end
  end

  assign dout_vld_o = (state_q == ST_HOLD);
  assign dout_chg_o = chg_q;

endmodule

// File: tb/tb_qick_bit2vec.sv
module tb_qick_bit2vec;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic        sticky;
  logic        rdy;

  logic [15:0] dout_a, dout_b;
  logic        vld_a, vld_b, chg_a, chg_b;

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a: defaults. Instance b: 4 active inputs, 3-stage synchronizer.
  qick_bit2vec #(.OUT_DW(16), .IN_QTY(16), .SYNC_ST(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
    .din4(din[4]), .din5(din[5]), .din6(din[6]), .din7(din[7]),
    .din8(din[8]), .din9(din[9]), .din10(din[10]), .din11(din[11]),
    .din12(din[12]), .din13(din[13]), .din14(din[14]), .din15(din[15]),
    .sticky_i(sticky), .dout_rdy_i(rdy),
    .dout_o(dout_a), .dout_vld_o(vld_a), .dout_chg_o(chg_a)
  );

  qick_bit2vec #(.OUT_DW(16), .IN_QTY(4), .SYNC_ST(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
    .din4(din[4]), .din5(din[5]), .din6(din[6]), .din7(din[7]),
    .din8(din[8]), .din9(din[9]), .din10(din[10]), .din11(din[11]),
    .din12(din[12]), .din13(din[13]), .din14(din[14]), .din15(din[15]),
    .sticky_i(sticky), .dout_rdy_i(rdy),
    .dout_o(dout_b), .dout_vld_o(vld_b), .dout_chg_o(chg_b)
  );

  // Reference model: per-instance latency line of sampled inputs plus the
  // handshake rules expressed as "holding a snapshot or not".
  int          m_lat  [2] = '{2, 3};
  logic [15:0] m_mask [2] = '{16'hFFFF, 16'h000F};
  logic [15:0] m_line [2][4];
  logic [15:0] m_prev [2];
  logic [15:0] m_pend [2];
  logic [15:0] m_dout [2];
  bit          m_hold [2];
  bit          m_chg  [2];
  bit          m_mode [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) m_line[i][k] = '0;
      m_prev[i] = '0; m_pend[i] = '0; m_dout[i] = '0;
      m_hold[i] = 0;  m_chg[i] = 0;   m_mode[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    logic [15:0] lvl, rise, acc;
    lvl  = m_line[i][m_lat[i]-1];
    rise = lvl & ~m_prev[i];
    m_chg[i] = 0;
    if (sticky != m_mode[i]) begin
      m_pend[i] = '0; m_dout[i] = '0; m_hold[i] = 0;
    end else if (!m_mode[i]) begin
      m_chg[i]  = (lvl != m_dout[i]);
      m_dout[i] = lvl;
      m_hold[i] = 0;
    end else begin
      acc = m_pend[i] | rise;
      if (!m_hold[i]) begin
        if (acc != 0) begin m_dout[i] = acc; m_pend[i] = '0; m_hold[i] = 1; end
      end else if (!rdy) begin
        m_pend[i] = acc;
      end else if (acc != 0) begin
        m_dout[i] = acc; m_pend[i] = '0;
      end else begin
        m_dout[i] = '0; m_hold[i] = 0;
      end
    end
    m_mode[i] = sticky;
    m_prev[i] = lvl;
    for (int k = 3; k > 0; k--) m_line[i][k] = m_line[i][k-1];
    m_line[i][0] = din & m_mask[i];
  endtask

  task automatic compare(input int i);
    logic [15:0] d;
    logic v, c;
    d = (i == 0) ? dout_a : dout_b;
    v = (i == 0) ? vld_a  : vld_b;
    c = (i == 0) ? chg_a  : chg_b;
    check($sformatf("i%0d_dout", i), {16'h0, d}, {16'h0, m_dout[i]});
    check($sformatf("i%0d_vld", i),  {31'h0, v}, {31'h0, m_hold[i]});
    check($sformatf("i%0d_chg", i),  {31'h0, c}, {31'h0, m_chg[i]});
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
    for (int i = 0; i < 2; i++) compare(i);
  endtask

  // Called at a negedge; asserts reset mid-cycle and checks it clears at once.
  task automatic apply_reset(input int cycles);
    #2 rst_n = 1'b0;
    #1;
    check("rst_dout_a", {16'h0, dout_a}, 32'h0);
    check("rst_vld_a",  {31'h0, vld_a},  32'h0);
    check("rst_dout_b", {16'h0, dout_b}, 32'h0);
    check("rst_vld_b",  {31'h0, vld_b},  32'h0);
    model_reset();
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit saw80;
    rst_n = 1'b0; din = '0; sticky = 1'b0; rdy = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("por_dout", {16'h0, dout_a}, 32'h0);
    check("por_vld",  {31'h0, vld_a},  32'h0);
    check("por_chg",  {31'h0, chg_a},  32'h0);
    rst_n = 1'b1;
    repeat (5) step();

    // LEVEL: din3 rises, visible SYNC_ST+1 cycles later with a change pulse.
    din = 16'h0008;
    repeat (3) step();
    check("lvl_d3_dout", {16'h0, dout_a}, 32'h0008);
    check("lvl_d3_chg",  {31'h0, chg_a},  32'h1);
    step();
    check("lvl_d3_chg1", {31'h0, chg_a},  32'h0);
    din = '0;
    repeat (5) step();

    // STICKY, ready low: two pulses, second is held pending.
    sticky = 1'b1;
    repeat (4) step();
    din = 16'h0001; step(); din = '0;
    repeat (3) step();
    din = 16'h0020; step(); din = '0;
    repeat (4) step();
    check("stk_first", {16'h0, dout_a}, 32'h0001);
    check("stk_vld",   {31'h0, vld_a},  32'h1);
    rdy = 1'b1; step();
    check("stk_b2b",   {16'h0, dout_a}, 32'h0020);
    check("stk_b2bv",  {31'h0, vld_a},  32'h1);
    step();
    check("stk_empty", {16'h0, dout_a}, 32'h0);
    check("stk_idlev", {31'h0, vld_a},  32'h0);

    // STICKY, ready held: din7 edge lands on the handshake cycle.
    saw80 = 0;
    din = 16'h0002; step();
    din = 16'h0080; step();
    din = '0;
    repeat (5) begin
      step();
      if (dout_a == 16'h0080 && vld_a) saw80 = 1;
    end
    check("d7_captured", {31'h0, saw80}, 32'h1);
    rdy = 1'b0;

    // din2 high through reset, STICKY.
    din = 16'h0004;
    apply_reset(2);
    repeat (3) step();
    check("rst_hi_stk",  {16'h0, dout_a}, 32'h0004);
    check("rst_hi_stkv", {31'h0, vld_a},  32'h1);
    rdy = 1'b1; step(); rdy = 1'b0;

    // din2 high through reset, LEVEL.
    sticky = 1'b0;
    apply_reset(2);
    repeat (3) step();
    check("rst_hi_lvl",  {16'h0, dout_a}, 32'h0004);
    check("rst_hi_lvlc", {31'h0, chg_a},  32'h1);

    // Mode change out of HOLD with pending bits.
    din = '0; sticky = 1'b1;
    repeat (3) step();
    din = 16'h0010; step(); din = '0;
    repeat (4) step();
    din = 16'h0003; step(); din = '0;
    repeat (4) step();
    sticky = 1'b0; step();
    check("mchg_vld",  {31'h0, vld_a},  32'h0);
    check("mchg_dout", {16'h0, dout_a}, 32'h0);
    din = 16'h0100;
    repeat (3) step();
    check("mchg_lvl",  {16'h0, dout_a}, 32'h0100);

    // Inputs above IN_QTY ignored on instance b.
    din = 16'hFFF0;
    repeat (6) step();
    check("inqty_zero", {16'h0, dout_b}, 32'h0);

    // Reset while holding a snapshot.
    sticky = 1'b1; din = '0;
    repeat (3) step();
    din = 16'h0200; step(); din = '0;
    repeat (4) step();
    check("hold_pre_rst", {31'h0, vld_a}, 32'h1);
    apply_reset(1);

    // Randomised traffic against the model.
    for (int n = 0; n < 2500; n++) begin
      din = 16'($urandom & $urandom & $urandom);
      rdy = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 59) == 0) sticky = ~sticky;
      if ($urandom_range(0, 399) == 0) apply_reset(2);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
